// File: rtl/ysyx_23060240_csr_trap.sv
// Machine-mode CSR file and trap controller for the RV32 core.
// Zicsr accesses, trap entry, mret return and the 64-bit counters.
module ysyx_23060240_csr_trap #(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST   = 32'h0,
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic [31:0] pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  input  logic        retire,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        mie
);

  localparam logic VEC = (VECTORED_EN != 0);

  logic        mie_q;
  logic        mpie_q;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [31:0] mscratch;
  logic [29:0] mepc_q;
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] mstatus_v;
  logic [31:0] mtvec_v;
  logic [31:0] mepc_v;
  logic        impl;
  logic        ro;
  logic        is_wr;
  logic        wen;
  logic [31:0] nv;
  logic [63:0] cyc_nxt;
  logic [63:0] ins_nxt;
  logic        unused_ok;

  assign mstatus_v = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mtvec_v   = {mtvec_base, 1'b0, mtvec_mode};
  assign mepc_v    = {mepc_q, 2'b00};
  assign mie       = mie_q;
  assign unused_ok = ^{trap_cause[30], pc[1:0]};

  always_comb begin
    csr_rdata = 32'h0;
    impl      = 1'b1;
    ro        = 1'b0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_v;
      12'h305: csr_rdata = mtvec_v;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc_v;
      12'h342: csr_rdata = mcause;
      12'hB00: csr_rdata = mcycle[31:0];
      12'hB80: csr_rdata = mcycle[63:32];
      12'hB02: csr_rdata = minstret[31:0];
      12'hB82: csr_rdata = minstret[63:32];
      12'h301: begin csr_rdata = 32'h4000_0100; ro = 1'b1; end
      12'hF14: begin csr_rdata = MHARTID;        ro = 1'b1; end
      12'hC00: begin csr_rdata = mcycle[31:0];   ro = 1'b1; end
      12'hC80: begin csr_rdata = mcycle[63:32];  ro = 1'b1; end
      12'hC02: begin csr_rdata = minstret[31:0]; ro = 1'b1; end
      12'hC82: begin csr_rdata = minstret[63:32]; ro = 1'b1; end
      default: impl = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read and never writes
  assign is_wr = (csr_op == 2'b01) |
                 ((csr_op != 2'b00) & (csr_wdata != 32'h0));
  assign csr_illegal = ((csr_op != 2'b00) & ~impl) | (ro & is_wr);
  assign wen = is_wr & impl & ~ro & ~trap_valid & ~mret;

  always_comb begin
    nv = csr_rdata;
    case (csr_op)
      2'b01:   nv = csr_wdata;
      2'b10:   nv = csr_rdata | csr_wdata;
      2'b11:   nv = csr_rdata & ~csr_wdata;
      default: nv = csr_rdata;
    endcase
  end

  always_comb begin
    cyc_nxt = mcycle + 64'd1;
    ins_nxt = minstret + {63'b0, retire};
    if (wen) begin
      case (csr_addr)
        12'hB00: cyc_nxt = {mcycle[63:32], nv};
        12'hB80: cyc_nxt = {nv, mcycle[31:0]};
        12'hB02: ins_nxt = {minstret[63:32], nv};
        12'hB82: ins_nxt = {nv, minstret[31:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    redirect    = trap_valid | mret;
    redirect_pc = 32'h0;
    if (trap_valid) begin
      redirect_pc = {mtvec_base, 2'b00};
      if (mtvec_mode & trap_cause[31])
        redirect_pc = {mtvec_base, 2'b00} + {trap_cause[29:0], 2'b00};
    end else if (mret) begin
      redirect_pc = mepc_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= MSTATUS_RST[3];
      mpie_q     <= MSTATUS_RST[7];
      mtvec_base <= MTVEC_RST[31:2];
      mtvec_mode <= VEC & MTVEC_RST[0];
      mscratch   <= 32'h0;
      mepc_q     <= 30'h0;
      mcause     <= 32'h0;
      mcycle     <= 64'h0;
      minstret   <= 64'h0;
    end else begin
      mcycle   <= cyc_nxt;
      minstret <= ins_nxt;
      if (trap_valid) begin
        mepc_q <= pc[31:2];
        mcause <= trap_cause;
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wen) begin
        case (csr_addr)
          12'h300: begin
            mie_q  <= nv[3];
            mpie_q <= nv[7];
          end
          12'h305: begin
            mtvec_base <= nv[31:2];
            mtvec_mode <= VEC & nv[0];
          end
          12'h340: mscratch <= nv;
          12'h341: mepc_q   <= nv[31:2];
          12'h342: mcause   <= nv;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_csr_trap.sv
// Bench for ysyx_23060240_csr_trap: directed vectors, a value-level CSR
// model checked every cycle, and literal expectations at key points.
module tb_ysyx_23060240_csr_trap;

  localparam logic [31:0] HART = 32'h0000_0017;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] pc;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic        mret;
  logic        retire;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mie;

  ysyx_23060240_csr_trap #(.MHARTID(HART)) dut (
    .clk(clk), .rst(rst),
    .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .pc(pc), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .mret(mret), .retire(retire),
    .redirect(redirect), .redirect_pc(redirect_pc), .mie(mie)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_status, m_tvec, m_scratch, m_epc, m_cause;
  logic [63:0] m_cyc, m_ins;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'h301: return 32'h4000_0100;
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a inside {12'h301, 12'hF14, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    return m_ro(a) || a inside {12'h300, 12'h305, 12'h340, 12'h341,
      12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic bit m_writes();
    return csr_op == 2'd1 || (csr_op != 2'd0 && csr_wdata != 0);
  endfunction

  function automatic bit m_illegal();
    return (csr_op != 0 && !m_known(csr_addr)) ||
           (m_ro(csr_addr) && m_writes());
  endfunction

  function automatic logic [31:0] m_rpc();
    logic [31:0] base;
    base = m_tvec & ~32'h3;
    if (trap_valid)
      return (m_tvec[0] && trap_cause[31]) ? base + (trap_cause << 2) : base;
    if (mret) return m_epc;
    return 32'h0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model state advance for one rising edge, from the inputs held there
  task automatic model_step();
    logic [31:0] old, nv;
    bit wr;
    if (rst) begin
      m_status = 32'h1800; m_tvec = 0; m_scratch = 0;
      m_epc = 0; m_cause = 0; m_cyc = 0; m_ins = 0;
      return;
    end
    old = m_read(csr_addr);
    case (csr_op)
      2'd1:    nv = csr_wdata;
      2'd2:    nv = old | csr_wdata;
      default: nv = old & ~csr_wdata;
    endcase
    wr = m_writes() && !m_illegal() && !trap_valid && !mret;
    if (wr && csr_addr == 12'hB00) m_cyc = {m_cyc[63:32], nv};
    else if (wr && csr_addr == 12'hB80) m_cyc = {nv, m_cyc[31:0]};
    else m_cyc = m_cyc + 1;
    if (wr && csr_addr == 12'hB02) m_ins = {m_ins[63:32], nv};
    else if (wr && csr_addr == 12'hB82) m_ins = {nv, m_ins[31:0]};
    else m_ins = m_ins + 64'(retire);
    if (trap_valid) begin
      m_epc = pc & ~32'h3;
      m_cause = trap_cause;
      m_status = 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
    end else if (mret) begin
      m_status = 32'h1880 | (m_status[7] ? 32'h8 : 32'h0);
    end else if (wr) begin
      case (csr_addr)
        12'h300: m_status = (nv & 32'h88) | 32'h1800;
        12'h305: m_tvec = nv & 32'hFFFF_FFFD;
        12'h340: m_scratch = nv;
        12'h341: m_epc = nv & ~32'h3;
        12'h342: m_cause = nv;
        default: ;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("rdata", csr_rdata, m_read(csr_addr));
        check("illegal", {31'b0, csr_illegal}, {31'b0, m_illegal()});
        check("redirect", {31'b0, redirect}, {31'b0, trap_valid | mret});
        check("redirect_pc", redirect_pc, m_rpc());
        check("mie", {31'b0, mie}, {31'b0, m_status[3]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    csr_op = 0; csr_wdata = 0; trap_valid = 0;
    mret = 0; retire = 0;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a,
                    input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                    input string nm);
    csr_addr = a; csr_op = 0;
    #1;
    check(nm, csr_rdata, exp);
  endtask

  initial begin
    idle();
    rst = 1; csr_addr = 0; pc = 0; trap_cause = 0;
    tick();
    rst = 0; chk_en = 1;
    rd(12'h300, 32'h1800, "rst_mstatus");
    rd(12'h305, 32'h0, "rst_mtvec");
    rd(12'hF14, HART, "rst_mhartid");
    rd(12'hB00, 32'h0, "rst_mcycle");
    tick();
    rd(12'hB00, 32'h1, "mcycle_one");

    wr(2'd1, 12'h305, 32'h8000_0001);
    trap_valid = 1; trap_cause = 32'h8000_0007; pc = 32'h8000_0040;
    #1 check("vec_pc", redirect_pc, 32'h8000_001C);
    trap_cause = 32'hb;
    #1 check("direct_pc", redirect_pc, 32'h8000_0000);
    tick(); idle();

    wr(2'd2, 12'h300, 32'h8);
    rd(12'h300, 32'h1808, "set_mie");
    trap_valid = 1; pc = 32'h8000_0104; trap_cause = 32'hb;
    tick(); idle();
    rd(12'h341, 32'h8000_0104, "trap_mepc");
    rd(12'h342, 32'hb, "trap_mcause");
    rd(12'h300, 32'h1880, "trap_mstatus");
    mret = 1;
    #1 check("mret_pc", redirect_pc, 32'h8000_0104);
    tick(); idle();
    rd(12'h300, 32'h1888, "mret_mstatus");

    wr(2'd3, 12'h300, 32'h8);
    rd(12'h300, 32'h1880, "clr_mie");
    wr(2'd1, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h1888, "mstatus_ones");
    wr(2'd1, 12'h300, 32'h0);
    rd(12'h300, 32'h1800, "mstatus_zero");
    wr(2'd2, 12'h300, 32'h8);
    rd(12'h300, 32'h1808, "set_again");
    wr(2'd3, 12'h300, 32'h8);
    rd(12'h300, 32'h1800, "clr_again");
    wr(2'd1, 12'h305, 32'h0000_3003);
    rd(12'h305, 32'h0000_3001, "mtvec_legal");

    csr_op = 1; csr_addr = 12'hF14; csr_wdata = 32'h5;
    #1 check("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
    tick(); idle();
    rd(12'hF14, HART, "mhartid_kept");
    csr_op = 2; csr_addr = 12'hC00; csr_wdata = 0;
    #1 check("ro_set0_legal", {31'b0, csr_illegal}, 32'h0);
    tick(); idle();
    csr_op = 2; csr_addr = 12'hC00; csr_wdata = 1;
    #1 check("ro_set1_illegal", {31'b0, csr_illegal}, 32'h1);
    tick(); idle();
    csr_op = 1; csr_addr = 12'h7C0; csr_wdata = 32'h1;
    #1 check("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
    check("unimpl_rdata", csr_rdata, 32'h0);
    tick(); idle();

    wr(2'd1, 12'hB02, 32'hFFFF_FFFF);
    wr(2'd1, 12'hB82, 32'h0);
    retire = 1;
    tick(); idle();
    rd(12'hB02, 32'h0, "minstret_wrap_lo");
    rd(12'hB82, 32'h1, "minstret_wrap_hi");
    retire = 1;
    wr(2'd1, 12'hB02, 32'h5);
    rd(12'hB02, 32'h5, "minstret_wr_wins");
    rd(12'hC82, 32'h1, "instreth_hold");

    wr(2'd1, 12'h340, 32'hAA);
    rd(12'h340, 32'hAA, "mscratch_wr");
    trap_valid = 1; pc = 32'h103; trap_cause = 32'h2;
    wr(2'd1, 12'h340, 32'h55);
    rd(12'h340, 32'hAA, "trap_drops_wr");
    rd(12'h341, 32'h100, "mepc_aligned");
    mret = 1;
    wr(2'd1, 12'h340, 32'h66);
    rd(12'h340, 32'hAA, "mret_drops_wr");

    wr(2'd1, 12'hB00, 32'hFFFF_FFFF);
    wr(2'd1, 12'hB80, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_max_lo");
    rd(12'hC80, 32'hFFFF_FFFF, "mcycle_max_hi");
    tick();
    rd(12'hB00, 32'h0, "mcycle_wrap_lo");
    rd(12'hB80, 32'h0, "mcycle_wrap_hi");

    rst = 1; trap_valid = 1; pc = 32'h200; trap_cause = 32'h3;
    wr(2'd1, 12'h340, 32'h77);
    rst = 0;
    rd(12'h340, 32'h0, "rst_wins_scratch");
    rd(12'h342, 32'h0, "rst_wins_cause");
    rd(12'h341, 32'h0, "rst_wins_mepc");
    rd(12'h300, 32'h1800, "rst_wins_status");
    tick();
    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_csr_trap.md
# ysyx_23060240_csr_trap

Machine-mode CSR file and trap controller for the single-issue RV32 core. It sits beside the register file in the execute/write-back path. It serves Zicsr read-modify-write accesses and handles exception entry (ecall and friends) and `mret` return. It also maintains the 64-bit `mcycle`/`minstret` counters. It generalises the earlier fixed-value CSR block:

- parametrised reset values,
- real `mstatus` interrupt-enable stacking,
- `mcause` taken from the requester,
- direct/vectored `mtvec`,
- set/clear operations,
- illegal-access detection.

## Interface
Parameters:
- `MSTATUS_RST`, default 32'h0000_1800: `mstatus` reset value. Bits 12:11 (MPP) are hardwired to 2'b11.
- `MTVEC_RST`, default 32'h0: `mtvec` reset value.
- `MHARTID`, default 32'h0: value of read-only `mhartid`.
- `VECTORED_EN`, default 1: when 0, `mtvec.MODE` is hardwired to 0.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `csr_addr` in 12: CSR address.
- `csr_op` in 2: access type. 00 none, 01 write (csrrw), 10 set (csrrs), 11 clear (csrrc).
- `csr_wdata` in 32: operand (rs1 or zimm, already zero-extended).
- `csr_rdata` out 32: combinational old value of the addressed CSR; 0 if unimplemented.
- `csr_illegal` out 1: combinational; the access is illegal.
- `pc` in 32: PC of the instruction currently in this stage.
- `trap_valid` in 1: take a trap this cycle.
- `trap_cause` in 32: `mcause` value for the trap (ecall = 32'hb).
- `mret` in 1: an `mret` instruction is executing.
- `retire` in 1: an instruction retires this cycle.
- `redirect` out 1: combinational; equals `trap_valid | mret`.
- `redirect_pc` out 32: combinational next-PC target.
- `mie` out 1: current `mstatus.MIE`.

## Operation
CSR map:
- Read/write: 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0xB00 mcycle, 0xB80 mcycleh, 0xB02 minstret, 0xB82 minstreth.
- Read-only: 0x301 misa (32'h4000_0100), 0xF14 mhartid (`MHARTID`), and the user shadows 0xC00/0xC80/0xC02/0xC82 (cycle/cycleh/instret/instreth).

Write value and legalisation:
- New value = `csr_wdata` (write), `old | csr_wdata` (set), or `old & ~csr_wdata` (clear).
- `mstatus` implements only MIE (bit 3), MPIE (bit 7) and MPP (12:11 = 11). All other bits read 0 and writes to them are ignored.
- `mtvec`: bit 1 reads 0. Bit 0 is writable only if `VECTORED_EN`=1.
- `mepc`: bits 1:0 read 0.

Illegal access (`csr_illegal`=1):
- `csr_op`!=00 and the address is unimplemented; or
- write to a read-only CSR; or
- set/clear to a read-only CSR with `csr_wdata`!=0.

An illegal access modifies no state. Set/clear with `csr_wdata`==0 is a pure read and is legal.

Trap entry (`trap_valid`=1):
- `mepc` <= `pc` & ~3
- `mcause` <= `trap_cause`
- MPIE <= MIE
- MIE <= 0
- Any CSR write requested in the same cycle is suppressed.

`mret` (with `trap_valid`=0):
- MIE <= MPIE
- MPIE <= 1
- A simultaneous CSR write is suppressed.

Priority: `rst` > `trap_valid` > `mret` > CSR write.

`redirect_pc`:
- Trap in direct mode (or `trap_cause[31]`=0): `{mtvec[31:2],2'b00}`.
- Trap in vectored mode with `trap_cause[31]`=1: base + `{trap_cause[29:0],2'b00}`.
- `mret` only: current `mepc`.
- Neither: 0.

Counters:
- `mcycle` (64-bit) increments by 1 every cycle out of reset.
- `minstret` increments by 1 when `retire`=1.
- Both wrap from 2^64-1 to 0. The carry from the low half into the high half happens in the same cycle.
- A legal write to either half of a counter suppresses that counter's increment for that cycle. The written half takes the new value; the other half holds.

## Timing
- Reset values (after the first `clk` edge with `rst`=1): `mstatus`=`MSTATUS_RST` with MPP forced to 11; `mtvec`=`MTVEC_RST` legalised; all other writable CSRs and both counters = 0; `mie`=`MSTATUS_RST[3]`.
- Reads are zero-latency combinational. A read in the cycle of a write returns the old value; the new value is visible from the next cycle.
- Trap, `mret`, and CSR writes update state at the same edge that consumes them.
- `redirect`/`redirect_pc` are valid in the request cycle and are computed from pre-update state.
- `rst` asserted in the same cycle as a trap or write: reset wins and no side effects occur.

## Test plan
- Reset, then read 0x300/0x305/0xF14/0xB00 -> 32'h1800, 32'h0, `MHARTID`, 32'h0. One cycle later `mcycle` reads 1.
- csrrw 0x305 with 32'h8000_0001, then `trap_valid` with cause 32'h8000_0007 -> `redirect_pc`=32'h8000_001C. With cause 32'hb -> 32'h8000_0000.
- `mstatus` MIE=1, then a trap at pc=32'h8000_0104 -> `mepc`=32'h8000_0104, `mcause` = cause, `mstatus`=32'h1880. Then `mret` -> `redirect_pc`=32'h8000_0104 and `mstatus`=32'h1888.
- csrrs 0x300 with 32'h8, then csrrc 0x300 with 32'h8 -> reads 32'h1808, then 32'h1800. csrrw 0x300 with 32'hFFFF_FFFF -> reads 32'h1888.
- csrrw 0xF14 -> `csr_illegal`=1 and no state change. csrrs 0xC00 with 0 -> legal and returns `mcycle`. csrrw to 0x7C0 -> illegal, `csr_rdata`=0.
- Write `minstret`=32'hFFFF_FFFF and `minstreth`=0, then `retire`=1 for one cycle -> `minstret`=0 and `minstreth`=1. A trap and a CSR write in the same cycle -> write dropped.
